// File: rtl/piso_pkg.sv
// Stream conventions shared by the PISO feeder and the serial sequence detector:
// FSM state encodings, counter widths and a counter-width helper.
package piso_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  localparam int GAP_W = 4;

  // Bits needed to hold any remaining-bit count from 0 up to width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the serial detector; out_bit is 0 unless bit_valid.
// Optional even-parity trailer bit is enabled with `define PISO_PARITY_EN.
module piso_bit_feeder
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_bit,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // With parity the count covers one extra bit-cycle, so cnt==0 lands on the parity bit.
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1 + PAR_BITS);

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [GAP_W-1:0] gcnt;
  logic             par;
  logic             last;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign last       = (state == SHIFT) && (cnt == '0);
  assign data_ready = (state == IDLE) || ((GAP_CYCLES == 0) && last);
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE);

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par <= 1'b0;
    else if (accept) par <= ^data_in;
  end
`else
  assign par = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      out_bit   <= 1'b0;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
    end else if (accept) begin
      // Reload also covers the back-to-back case from the last bit of SHIFT.
      state     <= SHIFT;
      cnt       <= CNT_LOAD;
      sreg      <= adv(data_in);
      out_bit   <= head(data_in);
      bit_valid <= 1'b1;
      word_done <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            cnt       <= cnt - 1'b1;
            word_done <= (cnt == CW'(1));
            out_bit   <= ((PAR_BITS != 0) && (cnt == CW'(1))) ? par : head(sreg);
            sreg      <= adv(sreg);
          end else begin
            out_bit   <= 1'b0;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              gcnt  <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        GAP: begin
          if (gcnt == '0) state <= IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
